// File: rtl/pipeline_pkg.sv
// Control-field layout and widths shared by the ID/EX, forwarding and EX/MEM logic.
package pipeline_pkg;
  localparam int REG_W = 5;
  localparam int WB_W  = 2;
  localparam int M_W   = 2;
  localparam int EX_W  = 4;

  localparam int REGWRITE = 0;
  localparam int MEMTOREG = 1;
  localparam int MEMREAD  = 0;
  localparam int MEMWRITE = 1;
  localparam int ALUSRC   = 0;
  localparam int REGDST   = 3;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctl_t;

  localparam ctl_t BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by the instruction in ID.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  output logic             load_use
);
  logic rs1_hit, rs2_hit;

  assign rs1_hit  = (ex_rd == id_rs1);
  assign rs2_hit  = id_uses_rs2 && (ex_rd == id_rs2);
  // x0 is never written, so a load targeting it cannot create a dependence.
  assign load_use = ex_valid && ex_memread && (ex_rd != '0) && id_valid && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and memory freeze.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifid_valid,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic [REG_W-1:0] ifid_rd,
  input  logic             ifid_uses_rs2,
  input  logic [N-1:0]     rdata1,
  input  logic [N-1:0]     rdata2,
  input  logic [N-1:0]     imm,
  input  logic [N-1:0]     pc,
  input  logic [WB_W-1:0]  ctl_wb,
  input  logic [M_W-1:0]   ctl_m,
  input  logic [EX_W-1:0]  ctl_ex,
  input  logic             flush,
  input  logic             mem_stall,
  output logic             idex_valid,
  output logic [REG_W-1:0] idex_rs1,
  output logic [REG_W-1:0] idex_rs2,
  output logic [REG_W-1:0] idex_rd,
  output logic [N-1:0]     idex_rdata1,
  output logic [N-1:0]     idex_rdata2,
  output logic [N-1:0]     idex_imm,
  output logic [N-1:0]     idex_pc,
  output logic [WB_W-1:0]  idex_wb,
  output logic [M_W-1:0]   idex_m,
  output logic [EX_W-1:0]  idex_ex,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             hazard_stall,
  output logic [CW-1:0]    stall_count
);
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic load_use;
  logic bubble;
  ctl_t ctl_in;

  hazard_detect u_hazard_detect (
    .ex_valid    (idex_valid),
    .ex_memread  (idex_m[MEMREAD]),
    .ex_rd       (idex_rd),
    .id_valid    (ifid_valid),
    .id_rs1      (ifid_rs1),
    .id_rs2      (ifid_rs2),
    .id_uses_rs2 (ifid_uses_rs2),
    .load_use    (load_use)
  );

  // A pending flush outranks the load-use stall: the dependent instruction is squashed anyway.
  assign hazard_stall = !rst && !mem_stall && !flush && load_use;
  assign pc_write     = rst || (!mem_stall && !hazard_stall);
  assign ifid_write   = pc_write;
  assign bubble       = flush || load_use;
  assign ctl_in       = ifid_valid ? ctl_t'{wb: ctl_wb, m: ctl_m, ex: ctl_ex} : BUBBLE;

  // ID -> EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_valid  <= 1'b0;
      idex_rs1    <= '0;
      idex_rs2    <= '0;
      idex_rd     <= '0;
      idex_rdata1 <= '0;
      idex_rdata2 <= '0;
      idex_imm    <= '0;
      idex_pc     <= '0;
      idex_wb     <= BUBBLE.wb;
      idex_m      <= BUBBLE.m;
      idex_ex     <= BUBBLE.ex;
      stall_count <= '0;
    end else if (!mem_stall) begin
      if (bubble) begin
        idex_valid  <= 1'b0;
        idex_rs1    <= '0;
        idex_rs2    <= '0;
        idex_rd     <= '0;
        idex_rdata1 <= '0;
        idex_rdata2 <= '0;
        idex_imm    <= '0;
        idex_pc     <= '0;
        idex_wb     <= BUBBLE.wb;
        idex_m      <= BUBBLE.m;
        idex_ex     <= BUBBLE.ex;
      end else begin
        idex_valid  <= ifid_valid;
        idex_rs1    <= ifid_rs1;
        idex_rs2    <= ifid_rs2;
        idex_rd     <= ifid_rd;
        idex_rdata1 <= rdata1;
        idex_rdata2 <= rdata2;
        idex_imm    <= imm;
        idex_pc     <= pc;
        idex_wb     <= ctl_in.wb;
        idex_m      <= ctl_in.m;
        idex_ex     <= ctl_in.ex;
      end
      if (hazard_stall) stall_count <= sat_inc(stall_count);
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural pipeline model.
module tb_id_ex_stage;
  localparam int N  = 32;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifid_valid, ifid_uses_rs2, flush, mem_stall;
  logic [4:0]    ifid_rs1, ifid_rs2, ifid_rd;
  logic [N-1:0]  rdata1, rdata2, imm, pc;
  logic [1:0]    ctl_wb, ctl_m;
  logic [3:0]    ctl_ex;
  logic          idex_valid, pc_write, ifid_write, hazard_stall;
  logic [4:0]    idex_rs1, idex_rs2, idex_rd;
  logic [N-1:0]  idex_rdata1, idex_rdata2, idex_imm, idex_pc;
  logic [1:0]    idex_wb, idex_m;
  logic [3:0]    idex_ex;
  logic [CW-1:0] stall_count;

  id_ex_stage #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_rd(ifid_rd), .ifid_uses_rs2(ifid_uses_rs2), .rdata1(rdata1), .rdata2(rdata2),
    .imm(imm), .pc(pc), .ctl_wb(ctl_wb), .ctl_m(ctl_m), .ctl_ex(ctl_ex), .flush(flush),
    .mem_stall(mem_stall), .idex_valid(idex_valid), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .idex_rd(idex_rd), .idex_rdata1(idex_rdata1), .idex_rdata2(idex_rdata2),
    .idex_imm(idex_imm), .idex_pc(idex_pc), .idex_wb(idex_wb), .idex_m(idex_m),
    .idex_ex(idex_ex), .pc_write(pc_write), .ifid_write(ifid_write),
    .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: what the ID/EX register should hold.
  logic          m_valid;
  logic [4:0]    m_rs1, m_rs2, m_rd;
  logic [N-1:0]  m_d1, m_d2, m_imm, m_pc;
  logic [1:0]    m_wb, m_m;
  logic [3:0]    m_ex;
  int            m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc = 0;
    m_wb = 0; m_m = 0; m_ex = 0; m_cnt = 0;
  endtask

  // A load in EX whose destination (not x0) is read by the valid instruction in ID.
  function automatic bit model_lu();
    bit reads;
    reads = (m_rd == ifid_rs1) || (ifid_uses_rs2 && m_rd == ifid_rs2);
    return m_valid && m_m[0] && (m_rd != 0) && ifid_valid && reads;
  endfunction

  task automatic model_edge();
    bit lu;
    lu = model_lu();
    if (mem_stall) return;
    if (flush || lu) begin
      bit v;
      v = m_valid;
      model_reset_regs();
      if (!flush && m_cnt < CMAX) m_cnt++;
    end else begin
      m_valid = ifid_valid;
      m_rs1 = ifid_rs1; m_rs2 = ifid_rs2; m_rd = ifid_rd;
      m_d1 = rdata1; m_d2 = rdata2; m_imm = imm; m_pc = pc;
      m_wb = ifid_valid ? ctl_wb : 2'b0;
      m_m  = ifid_valid ? ctl_m  : 2'b0;
      m_ex = ifid_valid ? ctl_ex : 4'b0;
    end
  endtask

  task automatic model_reset_regs();
    int keep;
    keep = m_cnt;
    model_reset();
    m_cnt = keep;
  endtask

  task automatic check_comb();
    bit hs;
    hs = !mem_stall && !flush && model_lu();
    check("hazard_stall", 64'(hazard_stall), 64'(hs));
    check("pc_write", 64'(pc_write), 64'(!mem_stall && !hs));
    check("ifid_write", 64'(ifid_write), 64'(!mem_stall && !hs));
  endtask

  task automatic check_regs();
    check("idex_valid", 64'(idex_valid), 64'(m_valid));
    check("idex_rs1", 64'(idex_rs1), 64'(m_rs1));
    check("idex_rs2", 64'(idex_rs2), 64'(m_rs2));
    check("idex_rd", 64'(idex_rd), 64'(m_rd));
    check("idex_data", {idex_rdata1, idex_rdata2}, {m_d1, m_d2});
    check("idex_imm_pc", {idex_imm, idex_pc}, {m_imm, m_pc});
    check("idex_ctl", 64'({idex_wb, idex_m, idex_ex}), 64'({m_wb, m_m, m_ex}));
    check("stall_count", 64'(stall_count), 64'(m_cnt));
  endtask

  task automatic drive(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit u2, input logic [1:0] wb,
                       input logic [1:0] m, input logic [3:0] ex);
    ifid_valid = v; ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_rd = rd; ifid_uses_rs2 = u2;
    ctl_wb = wb; ctl_m = m; ctl_ex = ex;
    rdata1 = $urandom; rdata2 = $urandom; imm = $urandom; pc = $urandom;
  endtask

  task automatic step();
    #1 check_comb();
    @(posedge clk);
    model_edge();
    #1 check_regs();
  endtask

  // Put a lw x5 into ID/EX.
  task automatic load_x5();
    flush = 0; mem_stall = 0;
    drive(1, 5'd1, 5'd2, 5'd5, 0, 2'b11, 2'b01, 4'b0011);
    step();
  endtask

  logic [1:0] snap_cnt;

  initial begin
    rst = 1; flush = 0; mem_stall = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check_regs();
    check("rst_pc_write", 64'(pc_write), 64'd1);
    check("rst_hazard", 64'(hazard_stall), 64'd0);
    @(posedge clk); #1 rst = 0;

    // Load-use on rs1: stall exactly one cycle, then the add enters.
    load_x5();
    drive(1, 5'd5, 5'd7, 5'd6, 1, 2'b01, 2'b00, 4'b1100);
    #1 check("lu_hazard", 64'(hazard_stall), 64'd1);
    check("lu_pc_write", 64'(pc_write), 64'd0);
    step();
    check("lu_bubble_rd", 64'({idex_valid, idex_wb, idex_rd}), 64'd0);
    step();
    check("lu_add_rs1", 64'(idex_rs1), 64'd5);
    check("lu_count", 64'(stall_count), 64'd1);

    // No stall: load to x0, I-type using x5 in rs2 slot, non-load writer.
    drive(1, 5'd1, 5'd2, 5'd0, 0, 2'b11, 2'b01, 4'b0011); step();
    drive(1, 5'd0, 5'd0, 5'd6, 1, 2'b01, 2'b00, 4'b0000); step();
    load_x5();
    drive(1, 5'd7, 5'd5, 5'd6, 0, 2'b01, 2'b00, 4'b0001); step();
    drive(1, 5'd1, 5'd2, 5'd5, 0, 2'b01, 2'b00, 4'b1000); step();
    drive(1, 5'd5, 5'd5, 5'd6, 1, 2'b01, 2'b00, 4'b1000); step();
    check("nolu_count", 64'(stall_count), 64'd1);

    // mem_stall for 3 cycles over a load-use, then exactly one stall.
    load_x5();
    drive(1, 5'd5, 5'd7, 5'd6, 1, 2'b01, 2'b00, 4'b1100);
    mem_stall = 1;
    repeat (3) step();
    check("ms_frozen_rd", 64'(idex_rd), 64'd5);
    mem_stall = 0;
    step(); step(); step();
    check("ms_count", 64'(stall_count), 64'd2);

    // flush with load-use: bubble, no stall.
    load_x5();
    drive(1, 5'd5, 5'd7, 5'd6, 1, 2'b01, 2'b00, 4'b1100);
    flush = 1;
    #1 check("fl_pc_write", 64'(pc_write), 64'd1);
    step();
    flush = 0;
    check("fl_count", 64'(stall_count), 64'd2);

    // Saturation.
    for (int i = 0; i < 5; i++) begin
      load_x5();
      drive(1, 5'd5, 5'd7, 5'd6, 1, 2'b01, 2'b00, 4'b1100);
      step(); step();
    end
    check("sat_count", 64'(stall_count), 64'(CMAX));

    // Reset asserted in the middle of a pending load-use stall.
    load_x5();
    drive(1, 5'd5, 5'd7, 5'd6, 1, 2'b01, 2'b00, 4'b1100);
    #2 rst = 1;
    #1 model_reset();
    check_regs();
    check("rstmid_pc_write", 64'(pc_write), 64'd1);
    check("rstmid_hazard", 64'(hazard_stall), 64'd0);
    @(posedge clk); #1 rst = 0;

    // Random traffic with a small register set to provoke dependences.
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] regs [4];
      regs[0] = 5'd0; regs[1] = 5'd5; regs[2] = 5'd6; regs[3] = 5'd7;
      drive(($urandom_range(0, 7) != 0), regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
            regs[$urandom_range(0, 3)], 1'($urandom), 2'($urandom), 2'($urandom), 4'($urandom));
      flush = ($urandom_range(0, 7) == 0);
      mem_stall = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage pipelined RISC core, combined with load-use hazard detection.
- Captures decoded operands and control from the ID stage every cycle.
- Inserts a one-cycle bubble and freezes PC/IF-ID on a load-use hazard; bubbles on branch flush; holds on global memory stall.
- Its registered rs1/rs2/WB outputs feed the EX-stage forwarding unit and ALU operand muxes.

Parameters:
- N, 32, datapath width (register data, immediate, PC).
- CW, 16, width of the saturating load-use stall counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifid_valid  in  1  IF/ID holds a real instruction.
- ifid_rs1, ifid_rs2, ifid_rd  in  5 each  decoded register indices.
- ifid_uses_rs2  in  1  instruction reads rs2 (R-type, store, branch).
- rdata1, rdata2  in  N each  register file read data.
- imm, pc  in  N each  sign-extended immediate; instruction PC.
- ctl_wb  in  2  [0]=RegWrite, [1]=MemtoReg.
- ctl_m  in  2  [0]=MemRead, [1]=MemWrite.
- ctl_ex  in  4  [0]=ALUSrc, [2:1]=ALUOp, [3]=RegDst.
- flush  in  1  branch taken, squash the ID instruction.
- mem_stall  in  1  global freeze from the memory system.
- idex_valid  out  1  registered valid.
- idex_rs1, idex_rs2, idex_rd  out  5 each  registered indices (to forwarding unit).
- idex_rdata1, idex_rdata2, idex_imm, idex_pc  out  N each  registered data.
- idex_wb, idex_m  out  2 each; idex_ex  out  4  registered control.
- pc_write, ifid_write  out  1 each  enable for PC / IF-ID register (combinational).
- hazard_stall  out  1  load-use stall this cycle (combinational).
- stall_count  out  CW  saturating count of load-use stall cycles.

Behaviour:
- Reset (async, any time, including mid-stall): all registered outputs are 0.
  - idex_valid=0; all control 0; all indices 0; stall_count=0.
  - pc_write=ifid_write=1; hazard_stall=0.
- load_use = idex_valid & idex_m[0] & (idex_rd!=0) & ifid_valid & (idex_rd==ifid_rs1 | (ifid_uses_rs2 & idex_rd==ifid_rs2)).
- Priority each rising edge: rst > mem_stall > flush > load_use > normal.
- mem_stall=1:
  - All ID/EX registers hold; pc_write=ifid_write=0; hazard_stall=0.
  - stall_count unchanged.
  - flush during mem_stall is ignored; its source keeps it asserted until the freeze lifts.
- flush=1 (no mem_stall): load bubble; pc_write=ifid_write=1; hazard_stall=0.
- load_use (no mem_stall, no flush):
  - Load bubble; pc_write=ifid_write=0; hazard_stall=1.
  - stall_count increments, saturating at 2^CW-1.
- Normal: capture all ID inputs; idex_valid<=ifid_valid; pc_write=ifid_write=1.
  - If ifid_valid=0, control fields are loaded as 0.
- Bubble:
  - idex_valid=0; idex_wb/m/ex=0.
  - idex_rs1/rs2/rd=0, so forwarding never matches a bubble.
  - Data fields=0.
- Stall length: after one bubble idex_m[0]=0, so a load-use stall lasts exactly one cycle. The dependent instruction enters ID/EX on the next edge, with the load now in EX/MEM.
- Load writing x0 or an unrelated register: no stall.
- Dependence through rs2 when ifid_uses_rs2=0 (I-type): no stall.
- pc_write, ifid_write and hazard_stall depend only on current ID/EX registers and inputs; no added latency.

Decomposition:
- Shared package (pipeline_pkg), shared with the forwarding unit and EX/MEM stage:
  - WB/M/EX bit-position constants: REGWRITE=0, MEMTOREG=1, MEMREAD=0, MEMWRITE=1, ALUSRC=0, REGDST=3.
  - Field widths 2/2/4; register index width 5; BUBBLE control constant.
- One sub-module, hazard_detect: combinational load_use compare. Instantiated here and reusable by a future branch-in-ID comparator.

Test Plan:
- Reset mid-stall: load in ID/EX, dependent add in IF/ID, assert rst -> all outputs 0, pc_write=1, stall_count=0 immediately (async).
- Load-use on rs1: lw x5 in ID/EX, then add x6,x5,x7 in ID:
  - Cycle 1 -> hazard_stall=1, pc_write=ifid_write=0; next edge idex_valid=0, idex_wb=0, idex_rd=0.
  - Cycle 2 -> add captured with idex_rs1=5; stall_count=1.
- No stall when not needed: lw x0 followed by use of x0 -> no stall; lw x5 then addi x6,x7,x5-in-rs2-slot with ifid_uses_rs2=0 -> no stall; non-load (idex_m=0) writing x5 -> no stall.
- mem_stall held 3 cycles concurrent with a load-use condition -> registers frozen, hazard_stall=0, stall_count unchanged; on release the stall occurs exactly once.
- flush and load_use together -> bubble inserted, pc_write=1, hazard_stall=0, stall_count unchanged.
- Counter saturation with CW=2: 5 load-use events -> stall_count reaches 3 and stays 3.
